// File: rtl/idct_8x8_engine_if.sv
// Coefficient-in / pixel-out stream pair of the 8x8 IDCT engine, plus its busy flag.
interface idct_8x8_engine_if #(
  parameter int COEF_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pixel;
  logic              busy;

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_pixel, busy
  );

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_pixel, busy
  );
endinterface

// File: rtl/idct_8x8_engine.sv
// Sequential 8x8 inverse DCT: row pass into a transpose buffer, column pass into an
// output buffer, one signed multiply-accumulate per cycle, clamped 8-bit pixels out.
module idct_8x8_engine #(
  parameter int COEF_W      = 12,
  parameter bit LEVEL_SHIFT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  idct_8x8_engine_if.slave io_bus
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_ROW  = 2'd1;
  localparam logic [1:0] S_COL  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;
  // 512 MACs per pass plus drain; the two passes together take exactly 1029 cycles.
  localparam logic [9:0] ROW_LAST = 10'd513;
  localparam logic [9:0] COL_LAST = 10'd514;

  logic [1:0]         r_state;
  logic [5:0]         r_in_idx;
  logic [5:0]         r_out_idx;
  logic [9:0]         r_cnt;
  logic [7:0]         r_pixel;

  logic [COEF_W-1:0]  r_coef_mem [64];
  logic signed [15:0] r_tbuf     [64];
  logic [7:0]         r_obuf     [64];

  logic               r_v1, r_pass1, r_first1, r_last1;
  logic [5:0]         r_widx1;
  logic [COEF_W-1:0]  r_coef_rd;
  logic signed [15:0] r_t_rd;
  logic signed [8:0]  r_c1;
  logic               r_v2, r_pass2, r_first2, r_last2;
  logic [5:0]         r_widx2;
  logic signed [31:0] r_prod;
  logic signed [31:0] r_acc;

  logic               w_in_hs, w_out_hs, w_issue;
  logic [2:0]         w_outer, w_inner, w_k;
  logic signed [15:0] w_a;
  logic signed [31:0] w_sum, w_sh, w_lvl;
  logic signed [15:0] w_t_sat;
  logic [7:0]         w_pix;

  // Q8 cosine table, folded onto the first quadrant of cos(m*pi/16).
  function automatic logic signed [8:0] cos_q8(input logic [2:0] n, input logic [2:0] k);
    logic [4:0] m;
    logic       neg;
    logic [7:0] mag;
    m = {1'b0, n, 1'b1} * {2'b00, k};
    if (m > 5'd16) m = 5'd0 - m;
    neg = (m > 5'd8);
    if (neg) m = 5'd16 - m;
    case (m)
      5'd0:    mag = 8'd128;
      5'd1:    mag = 8'd126;
      5'd2:    mag = 8'd118;
      5'd3:    mag = 8'd106;
      5'd4:    mag = 8'd91;
      5'd5:    mag = 8'd71;
      5'd6:    mag = 8'd49;
      5'd7:    mag = 8'd25;
      default: mag = 8'd0;
    endcase
    if (k == 3'd0) return 9'sd91;
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  assign w_in_hs  = (r_state == S_LOAD) && io_bus.in_valid;
  assign w_out_hs = (r_state == S_OUT) && io_bus.out_ready;
  assign w_issue  = ((r_state == S_ROW) || (r_state == S_COL)) && !r_cnt[9];
  assign w_outer  = r_cnt[8:6];
  assign w_inner  = r_cnt[5:3];
  assign w_k      = r_cnt[2:0];

  assign io_bus.in_ready  = (r_state == S_LOAD);
  assign io_bus.out_valid = (r_state == S_OUT);
  assign io_bus.busy      = (r_state != S_LOAD);
  assign io_bus.out_pixel = r_pixel;

  assign w_a = r_pass1 ? r_t_rd : 16'($signed(r_coef_rd));

  always_comb begin
    w_sum = (r_first2 ? 32'sd0 : r_acc) + r_prod;
    w_sh  = (w_sum + 32'sd128) >>> 8;
    if (w_sh > 32'sd32767)       w_t_sat = 16'sh7fff;
    else if (w_sh < -32'sd32768) w_t_sat = 16'sh8000;
    else                         w_t_sat = w_sh[15:0];
    w_lvl = w_sh + (LEVEL_SHIFT ? 32'sd128 : 32'sd0);
    if (w_lvl < 32'sd0)        w_pix = 8'd0;
    else if (w_lvl > 32'sd255) w_pix = 8'd255;
    else                       w_pix = w_lvl[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_in_idx  <= '0;
      r_out_idx <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (w_in_hs) begin
          r_in_idx <= r_in_idx + 6'd1;
          if (r_in_idx == 6'd63) begin
            r_state <= S_ROW;
            r_cnt   <= '0;
          end
        end
        S_ROW: begin
          r_cnt <= r_cnt + 10'd1;
          if (r_cnt == ROW_LAST) begin
            r_state <= S_COL;
            r_cnt   <= '0;
          end
        end
        S_COL: begin
          r_cnt <= r_cnt + 10'd1;
          if (r_cnt == COL_LAST) begin
            r_state   <= S_OUT;
            r_cnt     <= '0;
            r_out_idx <= '0;
          end
        end
        default: if (w_out_hs) begin
          r_out_idx <= r_out_idx + 6'd1;
          if (r_out_idx == 6'd63) begin
            r_state  <= S_LOAD;
            r_in_idx <= '0;
          end
        end
      endcase
    end
  end

  // Issue -> operand fetch -> multiply -> accumulate; the k==7 term closes each sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0; r_pass1 <= 1'b0; r_first1 <= 1'b0; r_last1 <= 1'b0;
      r_widx1 <= '0; r_c1 <= '0;
      r_v2 <= 1'b0; r_pass2 <= 1'b0; r_first2 <= 1'b0; r_last2 <= 1'b0;
      r_widx2 <= '0; r_prod <= '0; r_acc <= '0;
    end else begin
      r_v1     <= w_issue;
      r_pass1  <= (r_state == S_COL);
      r_first1 <= (w_k == 3'd0);
      r_last1  <= (w_k == 3'd7);
      r_widx1  <= {w_outer, w_inner};
      r_c1     <= cos_q8((r_state == S_COL) ? w_outer : w_inner, w_k);
      r_v2     <= r_v1;
      r_pass2  <= r_pass1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_widx2  <= r_widx1;
      r_prod   <= 32'(w_a) * 32'(r_c1);
      if (r_v2) r_acc <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) r_coef_mem[r_in_idx] <= io_bus.in_coef;
    r_coef_rd <= r_coef_mem[{w_outer, w_k}];
    r_t_rd    <= r_tbuf[{w_k, w_inner}];
    if (r_v2 && r_last2 && !r_pass2) r_tbuf[r_widx2] <= w_t_sat;
    if (r_v2 && r_last2 && r_pass2)  r_obuf[r_widx2] <= w_pix;
  end

  // Pixel 0 is prefetched on entry to OUT so it is valid in the first OUT cycle.
  always_ff @(posedge clk) begin
    if (reset)                                         r_pixel <= '0;
    else if ((r_state == S_COL) && (r_cnt == COL_LAST)) r_pixel <= r_obuf[6'd0];
    else if (w_out_hs)                                 r_pixel <= r_obuf[r_out_idx + 6'd1];
  end

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Self-checking bench for idct_8x8_engine: directed DC/clamp blocks, random blocks
// against an arithmetic IDCT model, backpressure and mid-operation resets.
module tb_idct_8x8_engine;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  idct_8x8_engine_if #(.COEF_W(12)) bus ();

  idct_8x8_engine #(.COEF_W(12), .LEVEL_SHIFT(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int rom   [8][8];
  int blk_x [64];
  int exp_p [64];
  int got_p [64];

  task automatic build_rom();
    real a, v;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++) begin
        a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        v = 256.0 * a * $cos(real'((2 * n + 1) * k) * 3.141592653589793 / 16.0);
        rom[n][k] = $rtoi($floor(v + 0.5));
      end
  endtask

  function automatic void ref_idct(input int x[64], output int p[64]);
    int     t[64];
    longint acc, v;
    for (int u = 0; u < 8; u++)
      for (int n2 = 0; n2 < 8; n2++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(x[u * 8 + k]) * rom[n2][k];
        v = (acc + 128) >>> 8;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        t[u * 8 + n2] = int'(v);
      end
    for (int n1 = 0; n1 < 8; n1++)
      for (int n2 = 0; n2 < 8; n2++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(t[k * 8 + n2]) * rom[n1][k];
        v = ((acc + 128) >>> 8) + 128;
        if (v < 0) v = 0;
        else if (v > 255) v = 255;
        p[n1 * 8 + n2] = int'(v);
      end
  endfunction

  task automatic gen_block(input int mode);
    foreach (blk_x[i]) blk_x[i] = 0;
    case (mode)
      0: foreach (blk_x[i]) blk_x[i] = int'($urandom_range(0, 4095)) - 2048;
      1: begin
        foreach (blk_x[i]) if ((i / 8) + (i % 8) < 4) blk_x[i] = int'($urandom_range(0, 128)) - 64;
        blk_x[0] = int'($urandom_range(0, 2000)) - 1000;
      end
      2: foreach (blk_x[i]) blk_x[i] = int'($urandom_range(0, 510)) - 255;
      default: blk_x[$urandom_range(1, 63)] = int'($urandom_range(0, 4095)) - 2048;
    endcase
  endtask

  // Feeds the first ncoef entries of blk_x; t_last is the cycle of the final handshake.
  task automatic send_block(input int ncoef, input bit rand_v, output int t_last, output bit ok);
    int i;
    bit hs, v;
    i = 0; hs = 1'b0; ok = 1'b0; t_last = 0;
    for (int g = 0; g < 4000; g++) begin
      @(negedge clk);
      if (hs) begin
        i++;
        if (i == ncoef) begin
          t_last = cyc - 1;
          ok     = 1'b1;
          break;
        end
      end
      v = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_coef  = 12'(blk_x[i]);
      hs = v && (bus.in_ready === 1'b1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_block(input int npix, input bit rand_r, output int t_ov, output int n_got,
                            output int ready_bad, output int stall_bad, output bit post_ok);
    int         n;
    bit         stalled, r;
    logic [7:0] held;
    n = 0; stalled = 1'b0; held = '0; t_ov = -1;
    ready_bad = 0; stall_bad = 0; post_ok = 1'b0;
    for (int g = 0; g < 6000 && n < npix; g++) begin
      if (g > 0) @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ready_bad++;
      if (stalled && bus.out_pixel !== held) stall_bad++;
      stalled = 1'b0;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_coef  = 12'($urandom);
      if (bus.out_valid === 1'b1) begin
        if (t_ov < 0) t_ov = cyc;
        r = rand_r ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.out_ready = r;
        if (r) begin
          got_p[n] = int'(bus.out_pixel);
          n++;
        end else begin
          stalled = 1'b1;
          held    = bus.out_pixel;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    bus.in_valid = 1'b0;
    n_got = n;
    if (n == 64) begin
      @(negedge clk);
      post_ok = (bus.busy === 1'b0) && (bus.in_ready === 1'b1) && (bus.out_valid === 1'b0);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_coef = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_pixel !== 8'd0) begin bad++; $display("FAIL reset_out_pixel got=%0d want=0", bus.out_pixel); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    reset = 1'b0;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_constant_blocks();
    int dc_tab[4] = '{0, 64, 2047, -2048};
    int px_tab[4] = '{128, 136, 255, 0};
    int tl, tov, ng, rb, sb, errs;
    bit ok, pok;
    for (int c = 0; c < 4; c++) begin
      foreach (blk_x[i]) blk_x[i] = 0;
      blk_x[0] = dc_tab[c];
      send_block(64, 1'b0, tl, ok);
      recv_block(64, 1'b0, tov, ng, rb, sb, pok);
      total++; if (!ok || ng != 64) begin bad++; $display("FAIL const_xfer dc=%0d sent_ok=%0d got_pixels=%0d want=64", dc_tab[c], ok, ng); end
      total++; if (tov - tl !== 1030) begin bad++; $display("FAIL const_latency dc=%0d got=%0d want=1030", dc_tab[c], tov - tl); end
      errs = 0;
      for (int i = 0; i < 64; i++) begin
        total++;
        if (got_p[i] !== px_tab[c]) begin
          bad++; errs++;
          if (errs <= 4) $display("FAIL const_pixel dc=%0d idx=%0d got=%0d want=%0d", dc_tab[c], i, got_p[i], px_tab[c]);
        end
      end
      total++; if (rb !== 0) begin bad++; $display("FAIL const_busy_ready dc=%0d bad_cycles=%0d want=0", dc_tab[c], rb); end
      total++; if (!pok) begin bad++; $display("FAIL const_return_load dc=%0d got=0 want=1", dc_tab[c]); end
      $display("block const dc=%0d pixel0=%0d latency=%0d", dc_tab[c], got_p[0], tov - tl);
    end
  endtask

  task automatic test_single_ac();
    int tl, tov, ng, rb, sb, errs;
    bit ok, pok;
    foreach (blk_x[i]) blk_x[i] = 0;
    blk_x[3 * 8 + 4] = 200;
    ref_idct(blk_x, exp_p);
    send_block(64, 1'b0, tl, ok);
    recv_block(64, 1'b0, tov, ng, rb, sb, pok);
    total++; if (!ok || ng != 64) begin bad++; $display("FAIL ac_xfer got_pixels=%0d want=64", ng); end
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_p[i] !== exp_p[i]) begin
        bad++; errs++;
        if (errs <= 4) $display("FAIL ac_pixel idx=%0d got=%0d want=%0d", i, got_p[i], exp_p[i]);
      end
    end
    $display("block single_ac X[3][4]=200 pixel0=%0d pixel63=%0d", got_p[0], got_p[63]);
  endtask

  task automatic test_random_blocks(input int nblk, input bit bp);
    int tl, tov, ng, rb, sb, errs;
    bit ok, pok;
    for (int b = 0; b < nblk; b++) begin
      gen_block(b % 4);
      ref_idct(blk_x, exp_p);
      send_block(64, bp, tl, ok);
      recv_block(64, bp, tov, ng, rb, sb, pok);
      total++; if (!ok || ng != 64) begin bad++; $display("FAIL rand_xfer blk=%0d got_pixels=%0d want=64", b, ng); end
      total++; if (tov - tl !== 1030) begin bad++; $display("FAIL rand_latency blk=%0d got=%0d want=1030", b, tov - tl); end
      errs = 0;
      for (int i = 0; i < 64; i++) begin
        total++;
        if (got_p[i] !== exp_p[i]) begin
          bad++; errs++;
          if (errs <= 4) $display("FAIL rand_pixel blk=%0d idx=%0d got=%0d want=%0d", b, i, got_p[i], exp_p[i]);
        end
      end
      total++; if (rb !== 0) begin bad++; $display("FAIL rand_busy_ready blk=%0d bad_cycles=%0d want=0", b, rb); end
      if (bp) begin
        total++; if (sb !== 0) begin bad++; $display("FAIL stall_stable blk=%0d changes=%0d want=0", b, sb); end
      end
      total++; if (!pok) begin bad++; $display("FAIL rand_return_load blk=%0d got=0 want=1", b); end
      $display("block rand bp=%0d blk=%0d mode=%0d pixel_errs=%0d", bp, b, b % 4, errs);
    end
  endtask

  task automatic test_reset_mid();
    int tl, tov, ng, rb, sb, errs;
    bit ok, pok;
    for (int s = 0; s < 3; s++) begin
      gen_block(2);
      if (s == 0) send_block(30, 1'b0, tl, ok);
      else send_block(64, 1'b0, tl, ok);
      if (s == 1) repeat (100) @(negedge clk);
      if (s == 2) recv_block(10, 1'b1, tov, ng, rb, sb, pok);
      reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready case=%0d got=%b want=1", s, bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid case=%0d got=%b want=0", s, bus.out_valid); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy case=%0d got=%b want=0", s, bus.busy); end
      total++; if (bus.out_pixel !== 8'd0) begin bad++; $display("FAIL midrst_out_pixel case=%0d got=%0d want=0", s, bus.out_pixel); end
      reset = 1'b0;
      gen_block(s);
      ref_idct(blk_x, exp_p);
      send_block(64, 1'b0, tl, ok);
      recv_block(64, 1'b0, tov, ng, rb, sb, pok);
      total++; if (tov - tl !== 1030) begin bad++; $display("FAIL midrst_latency case=%0d got=%0d want=1030", s, tov - tl); end
      errs = 0;
      for (int i = 0; i < 64; i++) begin
        total++;
        if (got_p[i] !== exp_p[i]) begin
          bad++; errs++;
          if (errs <= 4) $display("FAIL midrst_pixel case=%0d idx=%0d got=%0d want=%0d", s, i, got_p[i], exp_p[i]);
        end
      end
      $display("block after_reset case=%0d pixel_errs=%0d", s, errs);
    end
  endtask

  initial begin
    build_rom();
    test_reset();
    test_constant_blocks();
    test_single_ac();
    test_random_blocks(24, 1'b0);
    test_random_blocks(12, 1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idct_8x8_engine.md
# idct_8x8_engine

Sequential 8x8 two-dimensional inverse DCT engine. It is the decode-side counterpart of the forward DCT datapath and its per-(k1,k2) cosine-product LUTs. The block accepts 64 signed frequency coefficients over a valid/ready stream and computes the spatial block with a row pass, a transpose buffer and a column pass, using one multiply-accumulate per cycle. It then streams 64 clamped 8-bit pixels out over a second valid/ready stream.

## Interface
- COEF_W, 12, width of signed input coefficient
- LEVEL_SHIFT, 1, when 1 add 128 to each result before clamping
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  coefficient valid
- in_ready  output  1  engine accepts a coefficient this cycle
- in_coef  input  COEF_W  signed coefficient X[k1][k2], raster order index k1*8+k2
- out_valid  output  1  pixel valid
- out_ready  input  1  downstream accepts a pixel this cycle
- out_pixel  output  8  unsigned pixel x[n1][n2], raster order index n1*8+n2
- busy  output  1  high in every state except LOAD

## Operation
- Cosine ROM: C[n][k] = round(256·α(k)·cos((2n+1)kπ/16)), signed 9-bit Q8.
  - α(0) = √(1/8), so C[n][0] = 91.
  - α(k>0) = 1/2.
- States: LOAD, ROW, COL, OUT.
- LOAD
  - in_ready = 1.
  - Each handshake (in_valid & in_ready) writes the coefficient buffer at a 6-bit index, then increments the index.
  - The 64th handshake moves the state to ROW.
- ROW
  - For u = 0..7 and n2 = 0..7, accumulate over k2 = 0..7: acc += X[u][k2]·C[n2][k2]. The accumulator is at least 24 bits signed.
  - t[u][n2] = (acc + 128) >>> 8, arithmetic shift (floor), saturated to 16-bit signed, written to the transpose buffer.
- COL
  - For n1 = 0..7 and n2 = 0..7, accumulate over k1 = 0..7: acc += t[k1][n2]·C[n1][k1]. The accumulator is at least 28 bits signed.
  - r = ((acc + 128) >>> 8) + (LEVEL_SHIFT ? 128 : 0), clamped to [0,255], written to the output buffer.
- OUT
  - out_valid = 1 and out_pixel = outbuf[index].
  - Each handshake (out_valid & out_ready) advances the index.
  - The 64th handshake returns the state to LOAD with all indices at 0.
- in_ready = 0 in ROW, COL and OUT; input is never dropped or overwritten mid-block.
- There is no overlap between blocks: the next block is accepted only after the current block's 64th output handshake.

## Timing
- Reset values, taking effect on the first clock edge with reset high:
  - state = LOAD, all indices and accumulators = 0.
  - in_ready = 1, out_valid = 0, out_pixel = 0, busy = 0.
- Reset mid-operation (any state): the partial block is discarded, and the next cycle shows the LOAD reset values. Buffer contents need not be cleared.
- Latency: if the 64th input handshake occurs in cycle T, out_valid first rises in cycle T+1030. This is fixed regardless of data; the implementation pads pipeline drain cycles to meet it exactly.
- Backpressure: while out_valid = 1 and out_ready = 0, out_pixel and the index hold stable.
- Throughput: with out_ready held at 1, the 64 pixels appear in 64 consecutive cycles.
- busy is high from cycle T+1 through the cycle of the 64th output handshake. It is low, and in_ready is high, in the following cycle.
- in_valid during a non-LOAD state is ignored.

## Test plan
- All 64 coefficients 0, LEVEL_SHIFT=1 -> 64 pixels of 128; first out_valid at T+1030.
- DC-only block, X[0][0]=64, others 0 -> every pixel 136 (row 23, column 8, plus 128).
- Clamp limits: X[0][0]=2047 -> all pixels 255; X[0][0]=-2048 -> all pixels 0.
- Random blocks against a bit-exact reference model using the same ROM, rounding and saturation -> zero mismatches over 1000 blocks, including single-AC blocks such as X[3][4]=200.
- Backpressure: out_ready random at 50% and in_valid random at 50% -> pixel order and values unchanged, out_pixel stable while stalled, in_ready = 0 throughout ROW/COL/OUT.
- Reset asserted mid-LOAD (after 30 coefficients), mid-ROW and mid-OUT -> next cycle in_ready=1, out_valid=0, busy=0; a following full block decodes correctly.
